// File: rtl/line_pkg.sv
// Shared state encoding and widths for the line segment sequencer.
package line_pkg;

  localparam int COORD_W   = 16;
  localparam int SEG_W     = 2 * COORD_W;
  localparam int DEF_POS_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP
  } seq_state_t;

endpackage

// File: rtl/seg_fifo.sv
// Synchronous segment queue with registered occupancy count and flush.
module seg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                    pulse_clk,
  input  logic                    sys_rstH,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Flush discards everything, including a push or pop offered in the same cycle.
  always_ff @(posedge pulse_clk) begin
    if (sys_rstH || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pulse_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/line_seq_ctrl.sv
// Feeds queued relative segments to the interpolator, tracks absolute
// tool position from its step pulses and flags a stalled interpolator.
module line_seq_ctrl
  import line_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int POS_W   = DEF_POS_W,
  parameter int TIMEOUT = 65535
) (
  input  logic                      pulse_clk,
  input  logic                      sys_rstH,
  input  logic                      seg_validH,
  input  logic signed [COORD_W-1:0] seg_Xe,
  input  logic signed [COORD_W-1:0] seg_Ye,
  output logic                      seg_readyH,
  input  logic                      abortH,
  input  logic                      pos_clrH,
  output logic signed [COORD_W-1:0] Xe,
  output logic signed [COORD_W-1:0] Ye,
  output logic                      change_readyH,
  input  logic                      X_acc,
  input  logic                      Y_acc,
  input  logic                      X_dec,
  input  logic                      Y_dec,
  input  logic                      draw_overH,
  output logic signed [POS_W-1:0]   X_pos,
  output logic signed [POS_W-1:0]   Y_pos,
  output logic                      busyH,
  output logic                      seq_doneH,
  output logic                      errH
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  seq_state_t state;
  seq_state_t state_nxt;

  logic [SEG_W-1:0]        fifo_rd;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    flush;
  logic                    timeout_hit;
  logic [WD_W-1:0]         wdog;
  logic signed [POS_W-1:0] x_step;
  logic signed [POS_W-1:0] y_step;

  // Readiness comes from the registered count, so a pop never frees a slot early.
  assign seg_readyH = ~fifo_full;
  assign push       = seg_validH & seg_readyH & ~abortH;
  assign flush      = abortH | timeout_hit;

  seg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SEG_W)
  ) u_fifo (
    .pulse_clk (pulse_clk),
    .sys_rstH  (sys_rstH),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wr_data   ({seg_Xe, seg_Ye}),
    .rd_data   (fifo_rd),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    timeout_hit   = 1'b0;
    change_readyH = 1'b0;
    seq_doneH     = 1'b0;
    busyH         = (state != S_IDLE) || (fifo_count != '0);
    case (state)
      S_IDLE: begin
        if (!fifo_empty && !abortH) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        change_readyH = 1'b1;
        state_nxt     = S_RUN;
      end
      S_RUN: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (draw_overH) begin
          state_nxt = S_GAP;
        end else if (wdog == WD_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_GAP: begin
        seq_doneH = fifo_empty;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pulse_clk) begin
    if (sys_rstH) begin
      state <= S_IDLE;
      Xe    <= '0;
      Ye    <= '0;
      wdog  <= '0;
      errH  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) {Xe, Ye} <= fifo_rd;
      if (state == S_RUN) wdog <= wdog + 1'b1;
      else                wdog <= '0;
      if (timeout_hit) errH <= 1'b1;
    end
  end

  // +1 for acc alone, all-ones (-1) for dec alone, zero when both or neither.
  assign x_step = {{(POS_W-1){X_dec & ~X_acc}}, X_acc ^ X_dec};
  assign y_step = {{(POS_W-1){Y_dec & ~Y_acc}}, Y_acc ^ Y_dec};

  always_ff @(posedge pulse_clk) begin
    if (sys_rstH || pos_clrH) begin
      X_pos <= '0;
      Y_pos <= '0;
    end else begin
      X_pos <= X_pos + x_step;
      Y_pos <= Y_pos + y_step;
    end
  end

endmodule

// File: tb/tb_line_seq_ctrl.sv
// Directed bench for line_seq_ctrl with a behavioural interpolator model.
module tb_line_seq_ctrl;

  logic               pulse_clk = 1'b0;
  logic               sys_rstH;
  logic               seg_validH;
  logic signed [15:0] seg_Xe;
  logic signed [15:0] seg_Ye;
  logic               seg_readyH;
  logic               abortH;
  logic               pos_clrH;
  logic signed [15:0] Xe;
  logic signed [15:0] Ye;
  logic               change_readyH;
  logic               m_x_acc, m_x_dec, m_y_acc, m_y_dec;
  logic               f_x_acc, f_x_dec, f_y_acc, f_y_dec;
  logic               draw_overH;
  logic signed [31:0] X_pos;
  logic signed [31:0] Y_pos;
  logic               busyH;
  logic               seq_doneH;
  logic               errH;

  logic               interp_hang;
  int                 cr_count;
  int                 done_count;
  logic signed [15:0] log_x [32];
  logic signed [15:0] log_y [32];

  int checks;
  int errors;

  line_seq_ctrl #(
    .DEPTH   (4),
    .POS_W   (32),
    .TIMEOUT (16)
  ) dut (
    .pulse_clk     (pulse_clk),
    .sys_rstH      (sys_rstH),
    .seg_validH    (seg_validH),
    .seg_Xe        (seg_Xe),
    .seg_Ye        (seg_Ye),
    .seg_readyH    (seg_readyH),
    .abortH        (abortH),
    .pos_clrH      (pos_clrH),
    .Xe            (Xe),
    .Ye            (Ye),
    .change_readyH (change_readyH),
    .X_acc         (m_x_acc | f_x_acc),
    .Y_acc         (m_y_acc | f_y_acc),
    .X_dec         (m_x_dec | f_x_dec),
    .Y_dec         (m_y_dec | f_y_dec),
    .draw_overH    (draw_overH),
    .X_pos         (X_pos),
    .Y_pos         (Y_pos),
    .busyH         (busyH),
    .seq_doneH     (seq_doneH),
    .errH          (errH)
  );

  initial forever #5 pulse_clk = ~pulse_clk;

  // Interpolator model: one step per cycle (X first, then Y), then draw_overH.
  initial begin : interp_model
    int m_x;
    int m_y;
    bit m_active;
    m_x_acc = 0; m_x_dec = 0; m_y_acc = 0; m_y_dec = 0; draw_overH = 0;
    m_x = 0; m_y = 0; m_active = 0; cr_count = 0; done_count = 0;
    forever begin
      @(negedge pulse_clk);
      m_x_acc = 0; m_x_dec = 0; m_y_acc = 0; m_y_dec = 0; draw_overH = 0;
      if (seq_doneH === 1'b1) done_count++;
      if (sys_rstH) begin
        m_active = 0;
      end else if (change_readyH === 1'b1) begin
        if (cr_count < 32) begin
          log_x[cr_count] = Xe;
          log_y[cr_count] = Ye;
        end
        cr_count++;
        m_x = int'(Xe);
        m_y = int'(Ye);
        m_active = !interp_hang;
      end else if (m_active) begin
        if (m_x > 0)      begin m_x_acc = 1; m_x--; end
        else if (m_x < 0) begin m_x_dec = 1; m_x++; end
        else if (m_y > 0) begin m_y_acc = 1; m_y--; end
        else if (m_y < 0) begin m_y_dec = 1; m_y++; end
        else begin draw_overH = 1; m_active = 0; end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pulse_clk);
  endtask

  task automatic clear_pos();
    pos_clrH = 1; cyc(1); pos_clrH = 0; cyc(1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busyH !== 1'b0 && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (busyH !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle_timeout: busyH=%b after %0d cycles, expected 0", tag, busyH, n);
    end
  endtask

  task automatic test_reset();
    sys_rstH = 1; cyc(3);
    sys_rstH = 0; cyc(1);
    checks++; if (seg_readyH !== 1'b1) begin errors++; $display("[TB] FAIL reset_seg_ready: got %b expected 1", seg_readyH); end
    checks++; if (busyH !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busyH); end
    checks++; if (change_readyH !== 1'b0) begin errors++; $display("[TB] FAIL reset_change_ready: got %b expected 0", change_readyH); end
    checks++; if (seq_doneH !== 1'b0) begin errors++; $display("[TB] FAIL reset_seq_done: got %b expected 0", seq_doneH); end
    checks++; if (errH !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", errH); end
    checks++; if (X_pos !== 32'sd0 || Y_pos !== 32'sd0) begin errors++; $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (0,0)", X_pos, Y_pos); end
    checks++; if (Xe !== 16'sd0 || Ye !== 16'sd0) begin errors++; $display("[TB] FAIL reset_endpoint: got (%0d,%0d) expected (0,0)", Xe, Ye); end
  endtask

  task automatic test_single();
    int base_cr, base_done;
    base_cr = cr_count; base_done = done_count;
    seg_Xe = 16'sd3; seg_Ye = 16'sd2; seg_validH = 1;
    cyc(1); seg_validH = 0;
    checks++; if (change_readyH !== 1'b0) begin errors++; $display("[TB] FAIL single_cr_early: got %b expected 0", change_readyH); end
    checks++; if (busyH !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busyH); end
    cyc(1);
    checks++; if (change_readyH !== 1'b1) begin errors++; $display("[TB] FAIL single_cr_pulse: got %b expected 1", change_readyH); end
    checks++; if (Xe !== 16'sd3 || Ye !== 16'sd2) begin errors++; $display("[TB] FAIL single_endpoint: got (%0d,%0d) expected (3,2)", Xe, Ye); end
    cyc(1);
    checks++; if (change_readyH !== 1'b0) begin errors++; $display("[TB] FAIL single_cr_width: got %b expected 0", change_readyH); end
    cyc(6);
    checks++; if (seq_doneH !== 1'b1) begin errors++; $display("[TB] FAIL single_done_pulse: got %b expected 1", seq_doneH); end
    cyc(1);
    checks++; if (seq_doneH !== 1'b0 || busyH !== 1'b0) begin errors++; $display("[TB] FAIL single_after_gap: got done=%b busy=%b expected 0 0", seq_doneH, busyH); end
    checks++; if (X_pos !== 32'sd3 || Y_pos !== 32'sd2) begin errors++; $display("[TB] FAIL single_pos: got (%0d,%0d) expected (3,2)", X_pos, Y_pos); end
    checks++; if (Xe !== 16'sd3 || Ye !== 16'sd2) begin errors++; $display("[TB] FAIL single_hold: got (%0d,%0d) expected (3,2)", Xe, Ye); end
    checks++; if (cr_count - base_cr !== 1 || done_count - base_done !== 1) begin errors++; $display("[TB] FAIL single_counts: got cr=%0d done=%0d expected 1 1", cr_count - base_cr, done_count - base_done); end
  endtask

  task automatic test_queue_full();
    int base_cr, base_done;
    int exp_x[5];
    int exp_y[5];
    exp_x = '{6, 1, 0, -1, 0};
    exp_y = '{0, 0, 2, 0, -2};
    clear_pos();
    base_cr = cr_count; base_done = done_count;
    seg_Xe = 16'(exp_x[0]); seg_Ye = 16'(exp_y[0]); seg_validH = 1;
    cyc(1); seg_validH = 0;
    cyc(1);
    checks++; if (change_readyH !== 1'b1 || Xe !== 16'sd6) begin errors++; $display("[TB] FAIL queue_first_load: got cr=%b Xe=%0d expected 1 6", change_readyH, Xe); end
    for (int i = 1; i < 5; i++) begin
      seg_Xe = 16'(exp_x[i]); seg_Ye = 16'(exp_y[i]); seg_validH = 1;
      cyc(1);
    end
    checks++; if (seg_readyH !== 1'b0) begin errors++; $display("[TB] FAIL queue_full_ready: got %b expected 0", seg_readyH); end
    seg_Xe = 16'sd5; seg_Ye = 16'sd5; seg_validH = 1;
    cyc(1); seg_validH = 0;
    checks++; if (seg_readyH !== 1'b0) begin errors++; $display("[TB] FAIL queue_reject_ready: got %b expected 0", seg_readyH); end
    wait_idle(200, "queue");
    checks++; if (cr_count - base_cr !== 5) begin errors++; $display("[TB] FAIL queue_pulses: got %0d expected 5", cr_count - base_cr); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int'(log_x[base_cr + i]) !== exp_x[i] || int'(log_y[base_cr + i]) !== exp_y[i]) begin
        errors++;
        $display("[TB] FAIL queue_order_%0d: got (%0d,%0d) expected (%0d,%0d)", i, log_x[base_cr + i], log_y[base_cr + i], exp_x[i], exp_y[i]);
      end
    end
    checks++; if (done_count - base_done !== 1) begin errors++; $display("[TB] FAIL queue_done: got %0d expected 1", done_count - base_done); end
    checks++; if (X_pos !== 32'sd6 || Y_pos !== 32'sd0) begin errors++; $display("[TB] FAIL queue_pos: got (%0d,%0d) expected (6,0)", X_pos, Y_pos); end
    checks++; if (seg_readyH !== 1'b1) begin errors++; $display("[TB] FAIL queue_ready_after: got %b expected 1", seg_readyH); end
  endtask

  task automatic test_signs();
    int base_done;
    clear_pos();
    base_done = done_count;
    seg_Xe = -16'sd4; seg_Ye = 16'sd3; seg_validH = 1;
    cyc(1); seg_validH = 0;
    wait_idle(60, "signs_a");
    checks++; if (X_pos !== -32'sd4 || Y_pos !== 32'sd3) begin errors++; $display("[TB] FAIL signs_mid_pos: got (%0d,%0d) expected (-4,3)", X_pos, Y_pos); end
    seg_Xe = 16'sd4; seg_Ye = -16'sd3; seg_validH = 1;
    cyc(1); seg_validH = 0;
    wait_idle(60, "signs_b");
    checks++; if (X_pos !== 32'sd0 || Y_pos !== 32'sd0) begin errors++; $display("[TB] FAIL signs_final_pos: got (%0d,%0d) expected (0,0)", X_pos, Y_pos); end
    checks++; if (done_count - base_done !== 2) begin errors++; $display("[TB] FAIL signs_done: got %0d expected 2", done_count - base_done); end
  endtask

  task automatic test_abort();
    int base_cr, base_done;
    clear_pos();
    base_cr = cr_count; base_done = done_count;
    seg_Xe = 16'sd2; seg_Ye = 16'sd0; seg_validH = 1; cyc(1);
    seg_Xe = 16'sd0; seg_Ye = 16'sd1; cyc(1);
    seg_Xe = 16'sd1; seg_Ye = 16'sd1; cyc(1);
    seg_validH = 0; abortH = 1;
    checks++; if (busyH !== 1'b1 || change_readyH !== 1'b0) begin errors++; $display("[TB] FAIL abort_running: got busy=%b cr=%b expected 1 0", busyH, change_readyH); end
    cyc(1); abortH = 0;
    checks++; if (busyH !== 1'b1 || seg_readyH !== 1'b1) begin errors++; $display("[TB] FAIL abort_flushed: got busy=%b ready=%b expected 1 1", busyH, seg_readyH); end
    wait_idle(60, "abort");
    cyc(5);
    checks++; if (cr_count - base_cr !== 1) begin errors++; $display("[TB] FAIL abort_pulses: got %0d expected 1", cr_count - base_cr); end
    checks++; if (done_count - base_done !== 1) begin errors++; $display("[TB] FAIL abort_done: got %0d expected 1", done_count - base_done); end
    checks++; if (X_pos !== 32'sd2 || Y_pos !== 32'sd0) begin errors++; $display("[TB] FAIL abort_pos: got (%0d,%0d) expected (2,0)", X_pos, Y_pos); end
    checks++; if (busyH !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got %b expected 0", busyH); end
  endtask

  task automatic test_watchdog();
    int base_cr;
    interp_hang = 1;
    base_cr = cr_count;
    seg_Xe = 16'sd1; seg_Ye = 16'sd1; seg_validH = 1;
    cyc(1); seg_validH = 0;
    cyc(3);
    seg_Xe = 16'sd2; seg_Ye = 16'sd2; seg_validH = 1;
    cyc(1); seg_validH = 0;
    cyc(13);
    checks++; if (errH !== 1'b0 || busyH !== 1'b1) begin errors++; $display("[TB] FAIL wdog_early: got err=%b busy=%b expected 0 1", errH, busyH); end
    cyc(1);
    checks++; if (errH !== 1'b1) begin errors++; $display("[TB] FAIL wdog_err: got %b expected 1", errH); end
    checks++; if (busyH !== 1'b0 || seg_readyH !== 1'b1) begin errors++; $display("[TB] FAIL wdog_flush: got busy=%b ready=%b expected 0 1", busyH, seg_readyH); end
    cyc(3);
    checks++; if (errH !== 1'b1 || cr_count - base_cr !== 1) begin errors++; $display("[TB] FAIL wdog_sticky: got err=%b pulses=%0d expected 1 1", errH, cr_count - base_cr); end
    interp_hang = 0;
  endtask

  task automatic test_reset_mid();
    clear_pos();
    seg_Xe = 16'sd5; seg_Ye = 16'sd0; seg_validH = 1;
    cyc(1); seg_validH = 0;
    cyc(4);
    checks++; if (X_pos !== 32'sd2 || errH !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_before: got X_pos=%0d err=%b expected 2 1", X_pos, errH); end
    sys_rstH = 1;
    cyc(1);
    checks++; if (X_pos !== 32'sd0 || Y_pos !== 32'sd0) begin errors++; $display("[TB] FAIL rstmid_pos: got (%0d,%0d) expected (0,0)", X_pos, Y_pos); end
    checks++; if (Xe !== 16'sd0 || Ye !== 16'sd0) begin errors++; $display("[TB] FAIL rstmid_endpoint: got (%0d,%0d) expected (0,0)", Xe, Ye); end
    checks++; if (errH !== 1'b0 || busyH !== 1'b0 || change_readyH !== 1'b0 || seq_doneH !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_flags: got err=%b busy=%b cr=%b done=%b expected 0 0 0 0", errH, busyH, change_readyH, seq_doneH); end
    cyc(1); sys_rstH = 0;
    cyc(1);
    checks++; if (seg_readyH !== 1'b1 || busyH !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after: got ready=%b busy=%b expected 1 0", seg_readyH, busyH); end
  endtask

  task automatic test_pos_clr();
    f_x_acc = 1;
    cyc(1);
    checks++; if (X_pos !== 32'sd1) begin errors++; $display("[TB] FAIL posclr_step1: got %0d expected 1", X_pos); end
    cyc(1);
    checks++; if (X_pos !== 32'sd2) begin errors++; $display("[TB] FAIL posclr_step2: got %0d expected 2", X_pos); end
    pos_clrH = 1;
    cyc(1); pos_clrH = 0;
    checks++; if (X_pos !== 32'sd0) begin errors++; $display("[TB] FAIL posclr_priority: got %0d expected 0", X_pos); end
    f_x_dec = 1;
    cyc(1); f_x_acc = 0; f_x_dec = 0;
    checks++; if (X_pos !== 32'sd0) begin errors++; $display("[TB] FAIL posclr_acc_dec: got %0d expected 0", X_pos); end
    f_y_dec = 1;
    cyc(1); f_y_dec = 0;
    cyc(1);
    checks++; if (Y_pos !== -32'sd1 || X_pos !== 32'sd0) begin errors++; $display("[TB] FAIL posclr_ydec: got (%0d,%0d) expected (0,-1)", X_pos, Y_pos); end
  endtask

  initial begin
    checks = 0; errors = 0;
    sys_rstH = 1; seg_validH = 0; seg_Xe = '0; seg_Ye = '0;
    abortH = 0; pos_clrH = 0; interp_hang = 0;
    f_x_acc = 0; f_x_dec = 0; f_y_acc = 0; f_y_dec = 0;
    test_reset();
    test_single();
    test_queue_full();
    test_signs();
    test_abort();
    test_watchdog();
    test_reset_mid();
    test_pos_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule
